// File: rtl/conv_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_bank_sequencer
//  Description : Streams a 3-channel image from an input buffer, in raster
//                order, into an 8-kernel convolution bank. Collects the bank's
//                output pixels into an output buffer and signals completion.
//                Optional drain watchdog: define CONV_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_bank_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int IMG_WIDTH      = 56,
    parameter int IMG_HEIGHT     = 56,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data_0,
    input  logic [DATA_WIDTH-1:0] rd_data_1,
    input  logic [DATA_WIDTH-1:0] rd_data_2,
    output logic                  data_valid_in,
    output logic [DATA_WIDTH-1:0] data_in_0,
    output logic [DATA_WIDTH-1:0] data_in_1,
    output logic [DATA_WIDTH-1:0] data_in_2,
    input  logic                  valid_out_pixel,
    input  logic                  bank_done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    // Last raster address of the input image and the valid-convolution output count.
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_N_OUT     = ADDR_WIDTH'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2));
    localparam logic [ADDR_WIDTH-1:0] c_N_OUT_M1  = ADDR_WIDTH'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2) - 1);

    // Reject parameter sets the address arithmetic cannot represent.
    generate
        if ((IMG_WIDTH < 3) || (IMG_HEIGHT < 3) || (TIMEOUT_CYCLES < 1) ||
            ((64'd1 << ADDR_WIDTH) < 64'(IMG_WIDTH * IMG_HEIGHT))) begin : g_param_check
            $error("conv_bank_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FEED   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_data_valid;
    logic                  w_busy;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_out_full;
    logic                  w_timeout;

    assign w_busy  = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_rd_en = (r_state == S_FEED) && !pause;
    // r_wr_addr doubles as the output count; it saturates at c_N_OUT so extra outputs are dropped.
    assign w_wr_en = w_busy && valid_out_pixel && (r_wr_addr != c_N_OUT);
    // True once the final expected output is being (or has been) written.
    assign w_out_full = (r_wr_addr == c_N_OUT) || (w_wr_en && (r_wr_addr == c_N_OUT_M1));

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_error;

    // Fires on the last of TIMEOUT_CYCLES consecutive output-less DRAIN cycles.
    assign w_timeout = (r_state == S_DRAIN) && !valid_out_pixel &&
                       (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared by any output pixel, counts silent DRAIN cycles.
    always_ff @(posedge clk) begin
        if (reset || (r_state == S_IDLE) || valid_out_pixel) begin
            r_wdog <= '0;
        end else if (r_state == S_DRAIN) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Error flag lives only in the FINISH cycle that a timeout caused.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_timeout && !abort && !w_out_full && !bank_done;
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort wins over everything except start in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FEED;
                end
            end
            S_FEED: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_rd_en && (r_rd_addr == c_LAST_ADDR)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_out_full || bank_done || w_timeout) begin
                    w_state_next = S_FINISH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Read address: held at 0 outside an image, advances on each issued read.
    always_ff @(posedge clk) begin
        if (reset || abort || (r_state == S_IDLE)) begin
            r_rd_addr <= '0;
        end else if (w_rd_en) begin
            r_rd_addr <= (r_rd_addr == c_LAST_ADDR) ? '0 : r_rd_addr + 1'b1;
        end
    end

    // Write address / output count: advances on each accepted output pixel.
    always_ff @(posedge clk) begin
        if (reset || abort || (r_state == S_IDLE)) begin
            r_wr_addr <= '0;
        end else if (w_wr_en) begin
            r_wr_addr <= r_wr_addr + 1'b1;
        end
    end

    // Pixel strobe to the bank trails the read strobe by the buffer latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_en && !abort;
        end
    end

    assign busy          = w_busy;
    assign done          = (r_state == S_FINISH);
    assign rd_en         = w_rd_en;
    assign rd_addr       = r_rd_addr;
    assign data_valid_in = r_data_valid;
    assign data_in_0     = r_data_valid ? rd_data_0 : '0;
    assign data_in_1     = r_data_valid ? rd_data_1 : '0;
    assign data_in_2     = r_data_valid ? rd_data_2 : '0;
    assign wr_en         = w_wr_en;
    assign wr_addr       = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_conv_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_bank_sequencer
//  Description : Directed self-checking bench for conv_bank_sequencer on a
//                4x4 image (4 expected outputs, watchdog limit 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_bank_sequencer;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pause = 1'b0;
    logic          busy, done, error, rd_en, data_valid_in, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data_0 = '0, rd_data_1 = '0, rd_data_2 = '0;
    logic [DW-1:0] data_in_0, data_in_1, data_in_2;
    logic          valid_out_pixel = 1'b0;
    logic          bank_done = 1'b0;

    int vec  = 0;
    int errs = 0;

    conv_bank_sequencer #(
        .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
        .busy(busy), .done(done), .error(error),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .data_valid_in(data_valid_in),
        .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
        .valid_out_pixel(valid_out_pixel), .bank_done(bank_done),
        .wr_en(wr_en), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    // Input buffer model: one-cycle read latency, contents tagged by channel and address.
    function automatic logic [DW-1:0] pix(input int ch, input int a);
        return (32'(8'hA0 + ch) << 24) | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_0 <= pix(0, int'(rd_addr));
            rd_data_1 <= pix(1, int'(rd_addr));
            rd_data_2 <= pix(2, int'(rd_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        step();
        step();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, done, error, rd_en, data_valid_in, wr_en, rd_addr, wr_addr, data_in_0} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got b=%b d=%b e=%b re=%b dv=%b we=%b ra=%0d wa=%0d di=%h, expected all 0",
                     busy, done, error, rd_en, data_valid_in, wr_en, rd_addr, wr_addr, data_in_0);
        end
        step();
    endtask

    task automatic test_basic();
        int nw;
        nw = 0;
        valid_out_pixel = 1'b1;               // ignored in IDLE
        @(negedge clk);
        vec++;
        if (wr_en !== 1'b0) begin errs++; $display("FAIL idle_valid_ignored: wr_en=%b expected 0", wr_en); end
        step();
        valid_out_pixel = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_out_pixel = (i == 8) || (i == 11) || (i == 14);
            @(negedge clk);
            vec++;
            if ({busy, rd_en, rd_addr} !== {1'b1, 1'b1, AW'(i)}) begin
                errs++;
                $display("FAIL basic_read[%0d]: busy=%b rd_en=%b rd_addr=%0d expected 1 1 %0d", i, busy, rd_en, rd_addr, i);
            end
            vec++;
            if (data_valid_in !== (i > 0)) begin
                errs++;
                $display("FAIL basic_dv[%0d]: got %b expected %b", i, data_valid_in, (i > 0));
            end
            if (i > 0) begin
                vec++;
                if (data_in_1 !== pix(1, i - 1)) begin
                    errs++;
                    $display("FAIL basic_data[%0d]: got %h expected %h", i, data_in_1, pix(1, i - 1));
                end
            end
            if (valid_out_pixel) begin
                vec++;
                if ({wr_en, wr_addr} !== {1'b1, AW'(nw)}) begin
                    errs++;
                    $display("FAIL basic_write[%0d]: wr_en=%b wr_addr=%0d expected 1 %0d", i, wr_en, wr_addr, nw);
                end
                nw++;
            end
            step();
        end
        // First DRAIN cycle: last pixel still arriving, 4th output written.
        valid_out_pixel = 1'b1;
        @(negedge clk);
        vec++;
        if ({rd_en, data_valid_in, data_in_2, busy, done} !== {1'b0, 1'b1, pix(2, 15), 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL basic_drain: re=%b dv=%b di2=%h b=%b d=%b expected 0 1 %h 1 0",
                     rd_en, data_valid_in, data_in_2, busy, done, pix(2, 15));
        end
        vec++;
        if ({wr_en, wr_addr} !== {1'b1, AW'(3)}) begin
            errs++;
            $display("FAIL basic_last_write: wr_en=%b wr_addr=%0d expected 1 3", wr_en, wr_addr);
        end
        step();
        valid_out_pixel = 1'b0;
        start = 1'b1;                          // must be ignored in FINISH
        @(negedge clk);
        vec++;
        if ({done, error, busy, data_valid_in} !== 4'b1000) begin
            errs++;
            $display("FAIL basic_done: d=%b e=%b b=%b dv=%b expected 1 0 0 0", done, error, busy, data_valid_in);
        end
        step();
        start = 1'b0;
        @(negedge clk);
        vec++;
        if ({done, busy, rd_en} !== 3'b000) begin
            errs++;
            $display("FAIL finish_start_ignored: d=%b b=%b re=%b expected 0 0 0", done, busy, rd_en);
        end
        step();
    endtask

    task automatic test_pause();
        int exp_addr, held, reads, prev;
        logic exp_dv;
        exp_addr = 0; held = 0; reads = 0; prev = 0; exp_dv = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; (c < 40) && (reads < 16); c++) begin
            pause = (exp_addr == 5) && (held < 3);
            if (pause) held++;
            @(negedge clk);
            vec++;
            if ({rd_en, rd_addr, data_valid_in} !== {~pause, AW'(exp_addr), exp_dv}) begin
                errs++;
                $display("FAIL pause_cycle[%0d]: re=%b ra=%0d dv=%b expected %b %0d %b",
                         c, rd_en, rd_addr, data_valid_in, ~pause, exp_addr, exp_dv);
            end
            if (exp_dv) begin
                vec++;
                if (data_in_0 !== pix(0, prev)) begin
                    errs++;
                    $display("FAIL pause_data[%0d]: got %h expected %h", c, data_in_0, pix(0, prev));
                end
            end
            exp_dv = ~pause;
            if (!pause) begin
                prev = exp_addr;
                exp_addr++;
                reads++;
            end
            step();
        end
        pause = 1'b0;
        @(negedge clk);
        vec++;
        if ({rd_en, busy, data_valid_in, data_in_0} !== {1'b0, 1'b1, 1'b1, pix(0, 15)}) begin
            errs++;
            $display("FAIL pause_drain: re=%b b=%b dv=%b di0=%h expected 0 1 1 %h (reads=%0d)",
                     rd_en, busy, data_valid_in, data_in_0, pix(0, 15), reads);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, done} !== 2'b00) begin
            errs++;
            $display("FAIL pause_abort: b=%b d=%b expected 0 0", busy, done);
        end
        step();
    endtask

    task automatic test_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        abort = 1'b1;
        valid_out_pixel = 1'b1;
        @(negedge clk);
        vec++;
        if ({rd_en, rd_addr} !== {1'b1, AW'(9)}) begin
            errs++;
            $display("FAIL abort_at_addr: re=%b ra=%0d expected 1 9", rd_en, rd_addr);
        end
        step();
        abort = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, done, rd_en, data_valid_in, wr_en} !== 5'b0) begin
            errs++;
            $display("FAIL abort_idle: b=%b d=%b re=%b dv=%b we=%b expected all 0",
                     busy, done, rd_en, data_valid_in, wr_en);
        end
        step();
        valid_out_pixel = 1'b0;
        @(negedge clk);
        vec++;
        if (done !== 1'b0) begin errs++; $display("FAIL abort_no_done: done=%b expected 0", done); end
        // start and abort together in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, rd_en, rd_addr, wr_addr} !== {1'b1, 1'b1, AW'(0), AW'(0)}) begin
            errs++;
            $display("FAIL abort_restart: b=%b re=%b ra=%0d wa=%0d expected 1 1 0 0", busy, rd_en, rd_addr, wr_addr);
        end
        step();
        @(negedge clk);
        vec++;
        if ({rd_addr, data_valid_in, data_in_0} !== {AW'(1), 1'b1, pix(0, 0)}) begin
            errs++;
            $display("FAIL abort_reread: ra=%0d dv=%b di0=%h expected 1 1 %h", rd_addr, data_valid_in, data_in_0, pix(0, 0));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_out_pixel = (i >= 4) && (i <= 9);
            @(negedge clk);
            if (valid_out_pixel) begin
                vec++;
                if (i <= 7) begin
                    if ({wr_en, wr_addr} !== {1'b1, AW'(i - 4)}) begin
                        errs++;
                        $display("FAIL ovf_write[%0d]: we=%b wa=%0d expected 1 %0d", i, wr_en, wr_addr, i - 4);
                    end
                end else if (wr_en !== 1'b0) begin
                    errs++;
                    $display("FAIL ovf_suppress[%0d]: we=%b expected 0", i, wr_en);
                end
            end
            step();
        end
        valid_out_pixel = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, done} !== 2'b10) begin
            errs++;
            $display("FAIL ovf_drain: b=%b d=%b expected 1 0", busy, done);
        end
        step();
        @(negedge clk);
        vec++;
        if ({done, error, busy} !== 3'b100) begin
            errs++;
            $display("FAIL ovf_done: d=%b e=%b b=%b expected 1 0 0", done, error, busy);
        end
        step();
    endtask

    task automatic test_bank_done();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 17; i++) step();
        bank_done = 1'b1;
        @(negedge clk);
        vec++;
        if ({busy, done} !== 2'b10) begin
            errs++;
            $display("FAIL bankdone_drain: b=%b d=%b expected 1 0", busy, done);
        end
        step();
        bank_done = 1'b0;
        @(negedge clk);
        vec++;
        if ({done, error, busy} !== 3'b100) begin
            errs++;
            $display("FAIL bankdone_done: d=%b e=%b b=%b expected 1 0 0", done, error, busy);
        end
        step();
    endtask

    task automatic test_timeout();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) step();
        for (int d = 0; d < 2; d++) begin
            valid_out_pixel = 1'b1;
            @(negedge clk);
            vec++;
            if ({wr_en, wr_addr} !== {1'b1, AW'(d)}) begin
                errs++;
                $display("FAIL tmo_write[%0d]: we=%b wa=%0d expected 1 %0d", d, wr_en, wr_addr, d);
            end
            step();
        end
        valid_out_pixel = 1'b0;
        // Eight silent DRAIN cycles follow the last output.
        for (int d = 2; d < 10; d++) begin
            @(negedge clk);
            vec++;
            if ({busy, done} !== 2'b10) begin
                errs++;
                $display("FAIL tmo_wait[%0d]: b=%b d=%b expected 1 0", d, busy, done);
            end
            step();
        end
        @(negedge clk);
        vec++;
`ifdef CONV_SEQ_TIMEOUT_EN
        if ({done, error, busy} !== 3'b110) begin
            errs++;
            $display("FAIL tmo_done: d=%b e=%b b=%b expected 1 1 0", done, error, busy);
        end
        step();
        @(negedge clk);
        vec++;
        if ({done, error} !== 2'b00) begin
            errs++;
            $display("FAIL tmo_after: d=%b e=%b expected 0 0", done, error);
        end
`else
        if ({done, error, busy} !== 3'b001) begin
            errs++;
            $display("FAIL tmo_none: d=%b e=%b b=%b expected 0 0 1", done, error, busy);
        end
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        vec++;
        if ({done, busy} !== 2'b01) begin
            errs++;
            $display("FAIL tmo_still_busy: d=%b b=%b expected 0 1", done, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif
        step();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, done, error, rd_en, data_valid_in, wr_en, rd_addr, wr_addr, data_in_0} !== '0) begin
            errs++;
            $display("FAIL resetmid_outputs: b=%b d=%b e=%b re=%b dv=%b we=%b ra=%0d wa=%0d di=%h expected all 0",
                     busy, done, error, rd_en, data_valid_in, wr_en, rd_addr, wr_addr, data_in_0);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, rd_en, rd_addr, wr_addr} !== {1'b1, 1'b1, AW'(0), AW'(0)}) begin
            errs++;
            $display("FAIL resetmid_restart: b=%b re=%b ra=%0d wa=%0d expected 1 1 0 0", busy, rd_en, rd_addr, wr_addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_abort();
        test_overflow();
        test_bank_done();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
